// File: rtl/bcd_conv_arbiter_pkg.sv
// rtl/bcd_conv_arbiter_pkg.sv - shared constants for the shared BCD converter
package bcd_conv_arbiter_pkg;

    localparam int WIDTH_DEF  = 12;
    localparam int DIGITS_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // 10^n, used as the saturation threshold for an n-digit result
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// rtl/bcd_shift_core.sv - sequential double-dabble datapath with saturation
module bcd_shift_core
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  start_i,
    input  logic                  step_i,
    input  logic [WIDTH-1:0]      operand_i,
    output logic                  last_o,
    output logic [4*DIGITS-1:0]   result_o,
    output logic                  sat_o
);

    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [4*DIGITS-1:0] scratch_q, scratch_d;
    logic [4*DIGITS-1:0] adjusted, shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sat_q, sat_d;

    // add 3 to every digit that would reach 10 or more after the shift
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adjusted[4*DIGITS-2:0], opnd_q[WIDTH-1]};

    // capture on start, shift the operand out MSB-first on each step
    always_comb begin
        opnd_d    = opnd_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        if (clr_i) begin
            opnd_d    = '0;
            scratch_d = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
        end else if (start_i) begin
            opnd_d    = operand_i;
            scratch_d = '0;
            cnt_d     = '0;
            sat_d     = (64'(operand_i) >= LIMIT);
        end else if (step_i) begin
            opnd_d    = opnd_q << 1;
            scratch_d = shifted;
            cnt_d     = cnt_q + CW'(1);
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            opnd_q    <= opnd_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    // result is the value the final step would write, so it can be taken on that edge
    assign last_o   = (cnt_q == CW'(WIDTH - 1));
    assign result_o = sat_q ? {DIGITS{4'h9}} : shifted;
    assign sat_o    = sat_q;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin arbiter sharing one BCD converter
module bcd_conv_arbiter
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [1:0]          req,
    input  logic [WIDTH-1:0]    value0,
    input  logic [WIDTH-1:0]    value1,
    output logic [1:0]          ack,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd0,
    output logic [4*DIGITS-1:0] bcd1,
    output logic [1:0]          ovf
);

    logic [1:0]          state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_q, rr_d;
    logic [4*DIGITS-1:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d;
    logic [1:0]          ovf_q, ovf_d;
    logic                pick, start, step, last, sat;
    logic [4*DIGITS-1:0] result;

    // single requester wins outright; on a tie rr_q names the favoured one
    always_comb begin
        if (req == 2'b01) begin
            pick = 1'b0;
        end else if (req == 2'b10) begin
            pick = 1'b1;
        end else begin
            pick = rr_q;
        end
    end

    // FSM, pointer update and result holding
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        bcd0_d  = bcd0_q;
        bcd1_d  = bcd1_q;
        ovf_d   = ovf_q;
        start   = 1'b0;
        step    = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            rr_d    = 1'b0;
            bcd0_d  = '0;
            bcd1_d  = '0;
            ovf_d   = 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_d = pick;
                        rr_d    = ~pick;
                        start   = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    step = 1'b1;
                    if (last) begin
                        if (grant_q) begin
                            bcd1_d   = result;
                            ovf_d[1] = sat;
                        end else begin
                            bcd0_d   = result;
                            ovf_d[0] = sat;
                        end
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            bcd0_q  <= '0;
            bcd1_q  <= '0;
            ovf_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            bcd0_q  <= bcd0_d;
            bcd1_q  <= bcd1_d;
            ovf_q   <= ovf_d;
        end
    end

    bcd_shift_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .start_i   (start),
        .step_i    (step),
        .operand_i (grant_d ? value1 : value0),
        .last_o    (last),
        .result_o  (result),
        .sat_o     (sat)
    );

    // a clear arriving in DONE suppresses the completion pulse
    assign ack  = (state_q == ST_DONE && !clr) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy = (state_q != ST_IDLE);
    assign bcd0 = bcd0_q;
    assign bcd1 = bcd1_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - scoreboard bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;

    logic        clk, rst_n, clr;
    logic [1:0]  req, ack, ovf;
    logic [11:0] value0, value1, bcd0, bcd1;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        int          idx;
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    bcd_conv_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .req    (req),
        .value0 (value0),
        .value1 (value1),
        .ack    (ack),
        .busy   (busy),
        .bcd0   (bcd0),
        .bcd1   (bcd1),
        .ovf    (ovf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;
    always @(negedge clk) if (busy) busy_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // monitor: every ack must match the oldest expected completion
    initial begin
        exp_t        e;
        logic [11:0] got_bcd;
        logic        got_ovf;
        forever begin
            @(negedge clk);
            if (ack != 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack ack=%b expected none", ack);
                end else begin
                    e = sb.pop_front();
                    got_bcd = (e.idx != 0) ? bcd1 : bcd0;
                    got_ovf = ovf[e.idx];
                    if (ack != ((e.idx != 0) ? 2'b10 : 2'b01) || got_bcd != e.bcd || got_ovf != e.ovf) begin
                        errors++;
                        $display("FAIL ack_result ack=%b bcd=%h ovf=%b expected requester %0d bcd=%h ovf=%b",
                                 ack, got_bcd, got_ovf, e.idx, e.bcd, e.ovf);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [11:0] b, input logic o);
        exp_t e;
        e.idx = idx;
        e.bcd = b;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int idx, output int at);
        int n;
        n  = 0;
        at = -1;
        while (at < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[idx]) at = cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout requester=%0d got no ack expected ack within 40 cycles", idx);
        end
    endtask

    task automatic single(input int idx, input logic [11:0] v, input logic [11:0] b, input logic o);
        int at;
        if (idx == 0) value0 = v; else value1 = v;
        push(idx, b, o);
        req[idx] = 1'b1;
        wait_ack(idx, at);
        tick();
        req = 2'b00;
    endtask

    initial begin
        int issue, a0, a1, a2, a3;
        rst_n = 0; clr = 0; req = 0; value0 = 0; value1 = 0;
        repeat (3) tick();
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        check("reset_bcd0", bcd0, 0);
        check("reset_bcd1", bcd1, 0);
        check("reset_ovf", ovf, 0);
        rst_n = 1;
        tick();

        // 255: latency and busy width
        value0 = 12'd255;
        push(0, 12'h255, 1'b0);
        busy_cnt = 0;
        issue = cyc;
        req = 2'b01;
        wait_ack(0, a0);
        check("latency_255", a0 - issue, 13);
        tick();
        req = 2'b00;
        check("busy_cycles", busy_cnt, 13);
        check("busy_idle", busy, 0);

        // saturation boundary on requester 1
        single(1, 12'd999, 12'h999, 1'b0);
        single(1, 12'd1000, 12'h999, 1'b1);

        // both requesting: alternate, one conversion per 14 cycles
        value0 = 12'd12;
        value1 = 12'd4095;
        push(0, 12'h012, 1'b0);
        push(1, 12'h999, 1'b1);
        push(0, 12'h012, 1'b0);
        push(1, 12'h999, 1'b1);
        req = 2'b11;
        wait_ack(0, a0);
        wait_ack(1, a1);
        check("rr_gap_01", a1 - a0, 14);
        wait_ack(0, a2);
        check("rr_gap_10", a2 - a1, 14);
        wait_ack(1, a3);
        tick();
        req = 2'b00;

        // operand change after grant is ignored
        value0 = 12'd7;
        push(0, 12'h007, 1'b0);
        req = 2'b01;
        tick();
        tick();
        value0 = 12'd500;
        wait_ack(0, a0);
        tick();
        req = 2'b00;

        single(0, 12'd0, 12'h000, 1'b0);
        check("hold_bcd1", bcd1, 12'h999);
        check("hold_ovf", ovf, 2'b10);

        // clr mid-conversion
        value0 = 12'd300;
        req = 2'b01;
        repeat (5) tick();
        clr = 1;
        req = 2'b00;
        tick();
        clr = 0;
        check("clr_busy", busy, 0);
        check("clr_bcd0", bcd0, 0);
        check("clr_bcd1", bcd1, 0);
        check("clr_ovf", ovf, 0);
        repeat (20) tick();

        // pointer favours requester 0 again after clr
        value0 = 12'd5;
        value1 = 12'd6;
        push(0, 12'h005, 1'b0);
        push(1, 12'h006, 1'b0);
        req = 2'b11;
        wait_ack(0, a0);
        wait_ack(1, a1);
        tick();
        req = 2'b00;

        // asynchronous reset mid-conversion
        value0 = 12'd300;
        req = 2'b01;
        repeat (5) tick();
        rst_n = 0;
        req = 2'b00;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_bcd0", bcd0, 0);
        check("rst_bcd1", bcd1, 0);
        check("rst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1;
        repeat (20) tick();

        // pointer favours requester 0 after reset
        value0 = 12'd9;
        value1 = 12'd8;
        push(0, 12'h009, 1'b0);
        push(1, 12'h008, 1'b0);
        req = 2'b11;
        wait_ack(0, a0);
        wait_ack(1, a1);
        tick();
        req = 2'b00;
        repeat (3) tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 12: binary operand width in bits.
REQ-002 Parameter DIGITS, default 3: BCD digit count; result width is 4*DIGITS.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous soft clear, active-high.
REQ-006 req  input  2  per-requester conversion request, level-held until ack.
REQ-007 value0  input  WIDTH  requester 0 binary operand.
REQ-008 value1  input  WIDTH  requester 1 binary operand.
REQ-009 ack  output  2  one-cycle completion pulse per requester.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 bcd0  output  4*DIGITS  last held BCD result for requester 0.
REQ-012 bcd1  output  4*DIGITS  last held BCD result for requester 1.
REQ-013 ovf  output  2  per-requester saturation flag, updated with its result.

Function
REQ-014 The block SHALL share one sequential double-dabble converter between two requesters, with states IDLE, SHIFT, DONE.
REQ-015 In IDLE with any req bit high, at the next edge the block SHALL grant one requester, capture its operand, clear the scratch BCD register, zero the step counter, and enter SHIFT.
REQ-016 Arbitration SHALL be round-robin: with a single request, that requester wins; with both, the requester not granted last wins; the pointer SHALL favour requester 0 after reset.
REQ-017 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift left one bit, taking in the operand MSB-first.
REQ-018 After exactly WIDTH SHIFT cycles the block SHALL load the granted bcdN/ovf[N] and enter DONE.
REQ-019 In DONE, ack[granted] SHALL be high for exactly one cycle; the next state SHALL be IDLE.
REQ-020 Latency: req sampled at edge T gives ack high in the cycle after edge T+WIDTH (13 cycles for WIDTH=12); back-to-back conversions SHALL occur once per WIDTH+2 cycles.
REQ-021 Operands with value >= 10^DIGITS SHALL yield all digits 9 (0x999 for defaults) with ovf[N]=1; otherwise ovf[N]=0.
REQ-022 Operand changes after the grant edge SHALL not affect the in-flight result.
REQ-023 A req dropped before the grant SHALL not be served, and no ack SHALL be produced for it.
REQ-024 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-025 bcdN and ovf[N] SHALL hold their values between conversions, changing only for requester N's completion.
REQ-026 clr SHALL take priority in any state: next state IDLE, no ack, bcd0/bcd1/ovf cleared to 0, pointer reset to favour 0.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE and clear counter, scratch, and pointer; ack, busy, bcd0, bcd1, and ovf SHALL all read 0.
REQ-028 Reset asserted mid-conversion SHALL abort it with no ack, including on release.

Structure
REQ-029 WIDTH/DIGITS defaults and the state encoding (IDLE=0, SHIFT=1, DONE=2) SHALL live in the shared project constants package.
REQ-030 The adjust-and-shift datapath (scratch register, step counter, saturation compare) SHALL be the sub-module bcd_shift_core; arbitration, FSM, and result holding stay in bcd_conv_arbiter.

Verification
REQ-031 After reset, req=2'b01 with value0=255 -> ack[0] pulses 13 cycles after the sampling edge, bcd0=0x255, ovf[0]=0, busy high 13 cycles.
REQ-032 req=2'b10 with value1=999, then value1=1000 -> bcd1=0x999 with ovf[1]=0, then bcd1=0x999 with ovf[1]=1.
REQ-033 req=2'b11 held, value0=12, value1=4095 -> ack[0] first (bcd0=0x012), ack[1] 14 cycles later (bcd1=0x999, ovf[1]=1), then alternating.
REQ-034 Grant value0=7, then change value0=500 during SHIFT -> bcd0=0x007.
REQ-035 clr pulsed at SHIFT step 5, then rst_n pulsed low at SHIFT step 5 of a new request -> no ack, busy=0 next cycle, all outputs 0.
REQ-036 value0=0 -> bcd0=0x000, ovf[0]=0, ack[0] still pulses once.
